// File: rtl/div_hilo_unit.sv
// Radix-2 restoring divider producing quotient (LO) and remainder (HI) for DIV/DIVU.
// Latency: done strobes exactly 33 cycles after the accepting edge; busy stalls the pipe until then.
module div_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_result,
    output logic [WIDTH-1:0] lo_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               div0_q, div0_d;

    logic               dvd_neg, dvs_neg;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   fin_rem, fin_quo;
    logic               last_step;
    logic               accept;

    // Operand magnitudes; signs only matter for DIV.
    assign dvd_neg = signed_div & dividend[WIDTH-1];
    assign dvs_neg = signed_div & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;

    assign accept    = (state_q == S_IDLE) && start && !annul;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // One restoring step: shifted partial remainder needs WIDTH+1 bits, plus a borrow bit.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
        if (!diff[WIDTH+1]) begin
            step_rem = diff[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = rem_sh[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign fin_quo = q_neg_q ? -step_quo : step_quo;
    assign fin_rem = r_neg_q ? -step_rem : step_rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        div0_d  = div0_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    dvd_d   = dividend;
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    div0_d  = (divisor == '0);
                end
            end
            S_BUSY: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (last_step) begin
                        state_d = S_DONE;
                        // Divide-by-zero reports the raw dividend, bypassing sign fixup.
                        if (div0_q) begin
                            lo_d = '1;
                            hi_d = dvd_q;
                        end else begin
                            lo_d = fin_quo;
                            hi_d = fin_rem;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            div0_q  <= div0_d;
        end
    end

    // Stall drops in DONE so the pipeline advances while the commit happens.
    assign busy      = (state_q == S_BUSY) || accept;
    assign done      = (state_q == S_DONE);
    assign hi_result = hi_q;
    assign lo_result = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Bench for div_hilo_unit: directed table, randomized ops against an arithmetic model,
// and hand sequences for annul, reset mid-operation and back-to-back requests.
module tb_div_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] hi_result;
    logic [31:0] lo_result;

    div_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .hi_result  (hi_result),
        .lo_result  (lo_result)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int          dq_cyc[$];
    logic [31:0] dq_hi[$];
    logic [31:0] dq_lo[$];

    always @(negedge clk) begin
        if (done) begin
            dq_cyc.push_back(cyc);
            dq_hi.push_back(hi_result);
            dq_lo.push_back(lo_result);
        end
    end

    logic [31:0] last_hi;
    logic [31:0] last_lo;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (!s) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = 32'(q);
            hi = 32'(r);
        end
    endfunction

    function automatic void clear_q();
        dq_cyc.delete();
        dq_hi.delete();
        dq_lo.delete();
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eh, input logic [31:0] el, input string tag);
        int acc;
        int bcnt;
        clear_q();
        @(posedge clk);
        #1;
        dividend   = a;
        divisor    = b;
        signed_div = s;
        start      = 1'b1;
        @(negedge clk);
        check({tag, ".busy_req"}, {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
        bcnt  = 0;
        repeat (34) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        check({tag, ".done_cnt"}, dq_cyc.size(), 32'd1);
        check({tag, ".busy_cycles"}, bcnt, 32'd32);
        if (dq_cyc.size() > 0) begin
            check({tag, ".latency"}, dq_cyc[0] - acc, 32'd32);
            check({tag, ".lo"}, dq_lo[0], el);
            check({tag, ".hi"}, dq_hi[0], eh);
        end
        check({tag, ".lo_hold"}, lo_result, el);
        check({tag, ".hi_hold"}, hi_result, eh);
        last_hi = eh;
        last_lo = el;
    endtask

    initial begin
        logic [31:0] a, b, eh, el, eh2, el2;
        logic        s;
        int          acc;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vecs[5] = '{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234};
        vecs[6] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[7] = '{32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 32'd2,          32'hFFFF_FFFE};
        vecs[8] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};

        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        annul      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.done", {31'b0, done}, 32'd0);
        check("rst.hi", hi_result, 32'd0);
        check("rst.lo", lo_result, 32'd0);
        rst = 1'b0;
        last_hi = '0;
        last_lo = '0;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp_hi, vecs[i].exp_lo,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom();
            case ($urandom_range(0, 3))
                0: b = $urandom();
                1: begin
                    b = 32'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: b = 32'd0;
                default: begin
                    a = 32'($urandom_range(0, 1000));
                    b = $urandom();
                end
            endcase
            model(a, b, s, eh, el);
            run_op(a, b, s, eh, el, $sformatf("rnd%0d", i));
        end

        // annul mid-operation: abort without done, results untouched
        clear_q();
        @(posedge clk);
        #1;
        dividend = 32'd50; divisor = 32'd5; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        @(negedge clk);
        check("annul.busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("annul.no_done", dq_cyc.size(), 32'd0);
        check("annul.hi", hi_result, last_hi);
        check("annul.lo", lo_result, last_lo);

        // reset mid-operation
        clear_q();
        @(posedge clk);
        #1;
        dividend = 32'd50; divisor = 32'd5; signed_div = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst.busy", {31'b0, busy}, 32'd0);
        check("midrst.done", {31'b0, done}, 32'd0);
        check("midrst.hi", hi_result, 32'd0);
        check("midrst.lo", lo_result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst.no_done", dq_cyc.size(), 32'd0);
        run_op(32'd1000, 32'd33, 1'b0, 32'd10, 32'd30, "after_rst");

        // back-to-back: start held through DONE with the second operands
        model(32'hFFFF_FFF9, 32'd2, 1'b1, eh, el);
        model(32'd1000, 32'd7, 1'b0, eh2, el2);
        clear_q();
        @(posedge clk);
        #1;
        dividend = 32'hFFFF_FFF9; divisor = 32'd2; signed_div = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        dividend = 32'd1000; divisor = 32'd7; signed_div = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("b2b.done_cnt", dq_cyc.size(), 32'd2);
        if (dq_cyc.size() == 2) begin
            check("b2b.first_lat", dq_cyc[0] - acc, 32'd32);
            check("b2b.spacing", dq_cyc[1] - dq_cyc[0], 32'd34);
            check("b2b.lo1", dq_lo[0], el);
            check("b2b.hi1", dq_hi[0], eh);
            check("b2b.lo2", dq_lo[1], el2);
            check("b2b.hi2", dq_hi[1], eh2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_hilo_unit.md
Name: div_hilo_unit

Overview:
- Multi-cycle radix-2 restoring divider for the MIPS execute stage. Produces quotient and remainder for DIV/DIVU.
- It is the producer side of the HI/LO write interface: its done strobe drives the HI/LO register's divide write-enable, and its results drive hi_in/lo_in.
- While a divide is in flight it asserts a stall so the pipeline holds.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a divide; sampled only in IDLE.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; captured with start.
- annul  in  1  flush or exception; aborts the current or requested operation.
- dividend  in  WIDTH  rs operand; captured with start.
- divisor  in  WIDTH  rt operand; captured with start.
- busy  out  1  pipeline stall request (combinational).
- done  out  1  one-cycle strobe; results are valid this cycle (drives wediv).
- hi_result  out  WIDTH  remainder.
- lo_result  out  WIDTH  quotient.

Behaviour:
- Reset (async, any state): state=IDLE, done=0, hi_result=0, lo_result=0, counter=0, internal registers cleared. Reset during BUSY discards the operation and produces no done.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if start=1 and annul=0 at edge N:
  - Capture operands and signed_div.
  - Load |dividend| and |divisor|; magnitudes are taken only when signed_div=1.
  - Record q_neg = sign(dividend) XOR sign(divisor), r_neg = sign(dividend), div0 = (divisor==0).
  - counter=0; next state BUSY.
- BUSY: one restoring step per cycle. Shift {rem,quo} left by 1, trial-subtract the divisor magnitude, and keep the difference if it is non-negative (quotient bit=1).
  - counter increments each cycle.
  - After exactly WIDTH BUSY cycles (cycles N+1..N+32), go to DONE.
  - Sign fixup and the div0 override are applied on the transition into DONE.
- DONE: lasts one cycle (N+33). done=1 and the results are registered and stable. Next state IDLE.
- Fixed latency: the done cycle is N+33 for every operand, including divide-by-zero. There is no early termination.
- busy = (state==BUSY) OR (state==IDLE AND start AND NOT annul). busy is low in DONE so the pipeline advances in the done cycle.
- Signed results:
  - lo_result = q_neg ? -quo : quo.
  - hi_result = r_neg ? -rem : rem (remainder takes the dividend's sign).
- Overflow case 0x80000000 / 0xFFFFFFFF signed: lo_result=0x80000000, hi_result=0. This falls out of the magnitude arithmetic and needs no special case.
- Divide by zero (signed or unsigned): lo_result=0xFFFFFFFF, hi_result=dividend as captured (raw bits, no sign fixup).
- hi_result and lo_result hold their last values outside DONE. They update only on entry to DONE.
- annul:
  - In IDLE, it suppresses acceptance of start.
  - In BUSY, the next state is IDLE, no done is produced, and the results keep their prior values.
  - In DONE it has no effect; done still pulses because the commit is already decided.
- start while in BUSY or DONE is ignored. The pipeline must re-present the request after busy falls.
- start in the same cycle as DONE→IDLE is ignored. It is accepted the following cycle if still asserted.

Test Plan:
- DIVU 100 / 7, start at edge N → busy high N..N+32, done=1 only at cycle N+33, lo_result=14, hi_result=2.
- DIV -7 / 2 (0xFFFFFFF9 / 2) → lo_result=0xFFFFFFFD (-3), hi_result=0xFFFFFFFF (-1). DIV 7 / -2 → lo_result=-3, hi_result=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo_result=0x80000000, hi_result=0. DIVU 0xFFFFFFFF / 1 → lo_result=0xFFFFFFFF, hi_result=0.
- DIVU 1234 / 0 → done at N+33, lo_result=0xFFFFFFFF, hi_result=1234.
- Mid-operation events:
  - Start DIVU 50/5, assert annul at cycle N+10 → state IDLE, busy=0 from N+11, no done, results unchanged.
  - Separately, assert rst at N+20 → all outputs 0 immediately.
  - Afterwards, a new start runs a fresh 33-cycle divide correctly.
- Back-to-back: hold start high with new operands through the DONE cycle → second op accepted the cycle after DONE, second done exactly 34 cycles after the first, each result correct.
